// File: rtl/conf_int_add__rr_sched.sv
// Round-robin scheduler sharing one integer adder among NUM_REQ requesters.
// One transaction at a time: IDLE (arbitrate/accept) -> ISSUE (hold operands
// for ADDER_LAT+1 cycles) -> RESP (present registered sum until accepted).

// Per-requester handshake decode: grant, response valid and response accept.
module conf_int_add__rr_sched_lane #(
  parameter int REQ_IDX_W = 2,
  parameter int IDX       = 0
) (
  input  logic                 idle,
  input  logic                 resp,
  input  logic                 gnt_found,
  input  logic [REQ_IDX_W-1:0] gnt,
  input  logic [REQ_IDX_W-1:0] own_id,
  input  logic                 rsp_rdy,
  output logic                 req_rdy,
  output logic                 rsp_vld,
  output logic                 rsp_ack
);
  assign req_rdy = idle & gnt_found & (gnt == REQ_IDX_W'(IDX));
  assign rsp_vld = resp & (own_id == REQ_IDX_W'(IDX));
  assign rsp_ack = rsp_vld & rsp_rdy;
endmodule

module conf_int_add__rr_sched #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int NUM_REQ            = 4,
  parameter int REQ_IDX_W          = 2,
  parameter int ADDER_LAT          = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_b,
  output logic [DATA_PATH_BITWIDTH-1:0]         adder_a,
  output logic [DATA_PATH_BITWIDTH-1:0]         adder_b,
  input  logic [DATA_PATH_BITWIDTH-1:0]         adder_d,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  input  logic [NUM_REQ-1:0]                    rsp_ready,
  output logic [DATA_PATH_BITWIDTH-1:0]         rsp_d,
  output logic [REQ_IDX_W-1:0]                  rsp_id,
  output logic                                  busy
);
  localparam int W  = DATA_PATH_BITWIDTH;
  localparam int PW = REQ_IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                         state, state_n;
  logic [REQ_IDX_W-1:0]           rr_ptr, gnt_id, g;
  logic [2:0]                     lat_cnt;
  logic [W-1:0]                   op_a, op_b;
  logic                           g_found, accept, issue_done, rsp_done;
  logic [NUM_REQ-1:0][W-1:0]      a_v, b_v;
  logic [NUM_REQ-1:0]             rsp_ack_v;
  logic [2*NUM_REQ-1:0]           rot2;
  logic [NUM_REQ-1:0]             rot;
  logic [PW-1:0]                  off, gsum, g_inc, ptr_n;

  assign a_v = req_a;
  assign b_v = req_b;

  // Rotate the request vector so rr_ptr sits at bit 0, take the lowest set
  // bit, then rotate the offset back into an absolute requester index.
  always_comb begin
    rot2    = {req_valid, req_valid} >> rr_ptr;
    rot     = rot2[NUM_REQ-1:0];
    off     = '0;
    g_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off     = PW'(k);
        g_found = 1'b1;
      end
    end
    gsum = {1'b0, rr_ptr} + off;
    if (gsum >= PW'(NUM_REQ)) gsum = gsum - PW'(NUM_REQ);
    g     = gsum[REQ_IDX_W-1:0];
    g_inc = {1'b0, g} + PW'(1);
    ptr_n = (g_inc == PW'(NUM_REQ)) ? '0 : g_inc;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_lane
      conf_int_add__rr_sched_lane #(.REQ_IDX_W(REQ_IDX_W), .IDX(i)) u_lane (
        .idle      (state == IDLE),
        .resp      (state == RESP),
        .gnt_found (g_found),
        .gnt       (g),
        .own_id    (rsp_id),
        .rsp_rdy   (rsp_ready[i]),
        .req_rdy   (req_ready[i]),
        .rsp_vld   (rsp_valid[i]),
        .rsp_ack   (rsp_ack_v[i])
      );
    end
  endgenerate

  assign accept     = (state == IDLE) & g_found;
  assign issue_done = (state == ISSUE) & (lat_cnt == 3'(ADDER_LAT));
  assign rsp_done   = |rsp_ack_v;
  assign busy       = (state != IDLE);
  // Operand registers double as the adder drive: they only change on accept,
  // so the shared adder sees no toggling outside a transaction.
  assign adder_a    = op_a;
  assign adder_b    = op_b;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: RESP never falls straight into a new accept.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)     state_n = ISSUE;
      ISSUE:   if (issue_done) state_n = RESP;
      RESP:    if (rsp_done)   state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, count adder latency, capture the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      gnt_id  <= '0;
      rr_ptr  <= '0;
      lat_cnt <= '0;
      rsp_d   <= '0;
      rsp_id  <= '0;
    end else if (accept) begin
      op_a    <= a_v[g];
      op_b    <= b_v[g];
      gnt_id  <= g;
      rr_ptr  <= ptr_n[REQ_IDX_W-1:0];
      lat_cnt <= '0;
    end else if (state == ISSUE) begin
      lat_cnt <= lat_cnt + 3'd1;
      if (issue_done) begin
        rsp_d  <= adder_d;
        rsp_id <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_conf_int_add__rr_sched.sv
// Bench for conf_int_add__rr_sched: a combinational-adder instance driven
// through a grant/response scoreboard, plus a 2-cycle registered-adder instance.
module tb_conf_int_add__rr_sched;
  localparam int W = 16;
  localparam int N = 4;
  localparam logic [W-1:0] EXP_SUM [N] = '{16'h0003, 16'h0100, 16'h1335, 16'h0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- instance with combinational adder (ADDER_LAT=0)
  logic [N-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   adder_a, adder_b, adder_d, rsp_d;
  logic [1:0]     rsp_id;
  logic           busy;

  assign req_a   = {16'h8000, 16'h1234, 16'h00FF, 16'h0001};
  assign req_b   = {16'h8000, 16'h0101, 16'h0001, 16'h0002};
  assign adder_d = adder_a + adder_b;

  conf_int_add__rr_sched #(.DATA_PATH_BITWIDTH(W), .NUM_REQ(N), .REQ_IDX_W(2), .ADDER_LAT(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .adder_a(adder_a), .adder_b(adder_b),
    .adder_d(adder_d), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_d(rsp_d), .rsp_id(rsp_id), .busy(busy));

  // ---- instance with 2-stage registered adder (ADDER_LAT=2)
  logic [N-1:0]   r2_valid = '0, r2_ready, rsp2_valid, rsp2_ready = '1;
  logic [N*W-1:0] r2_a, r2_b;
  logic [W-1:0]   a2, b2, d2, rsp2_d, p1 = '0, p2 = '0;
  logic [1:0]     rsp2_id;
  logic           busy2;

  assign r2_a = {16'h0000, 16'h0000, 16'h0100, 16'hFFFF};
  assign r2_b = {16'h0000, 16'h0000, 16'h0023, 16'h0001};
  always @(posedge clk) begin
    p1 <= a2 + b2;
    p2 <= p1;
  end
  assign d2 = p2;

  conf_int_add__rr_sched #(.DATA_PATH_BITWIDTH(W), .NUM_REQ(N), .REQ_IDX_W(2), .ADDER_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_a(r2_a), .req_b(r2_b), .adder_a(a2), .adder_b(b2),
    .adder_d(d2), .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready),
    .rsp_d(rsp2_d), .rsp_id(rsp2_id), .busy(busy2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---- scoreboard
  typedef struct { int id; logic [W-1:0] d; int acc; } exp_t;
  exp_t sb_q[$];
  int   gq[$];

  // Monitor: checks grants against the expected order, pushes the expected
  // response, and pops/compares on every response handshake.
  initial begin : monitor
    bit           seen;
    logic [21:0]  held;
    int           gid, eg;
    exp_t         e;
    seen = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        seen = 1'b0;
      end else begin
        if (req_ready != '0) begin
          chk("req_ready_onehot", $countones(req_ready), 1);
          chk("req_ready_when_busy", {31'd0, busy}, 0);
          chk("req_ready_without_valid", {28'd0, req_ready & ~req_valid}, 0);
        end
        if ((req_valid & req_ready) != '0) begin
          gid = 0;
          for (int k = 0; k < N; k++) if (req_ready[k]) gid = k;
          checks++;
          if (gq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_grant actual=%0d required=none", gid);
          end else begin
            eg = gq.pop_front();
            if (eg != gid) begin
              fails++;
              $display("FAIL grant_order actual=%0d required=%0d", gid, eg);
            end
          end
          e.id = gid; e.d = EXP_SUM[gid]; e.acc = cyc;
          sb_q.push_back(e);
        end
        if (rsp_valid != '0) begin
          if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rsp actual=%0h required=none", rsp_valid);
          end else begin
            if (!seen) begin
              chk("rsp_latency", cyc - sb_q[0].acc, 2);
              chk("rsp_valid_onehot", {28'd0, rsp_valid}, 32'(1) << sb_q[0].id);
              held = {rsp_valid, rsp_d, rsp_id};
              seen = 1'b1;
            end else begin
              chk("rsp_hold", {10'd0, rsp_valid, rsp_d, rsp_id}, {10'd0, held});
            end
            if ((rsp_valid & rsp_ready) != '0) begin
              e = sb_q.pop_front();
              chk("rsp_d", {16'd0, rsp_d}, {16'd0, e.d});
              chk("rsp_id", {30'd0, rsp_id}, e.id);
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic wait_ready(input int id);
    bit ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", {31'd0, ok}, 1);
  endtask

  task automatic wait_rsp();
    bit ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin ok = 1'b1; break; end
    end
    chk("rsp_timeout", {31'd0, ok}, 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("drain_timeout", {31'd0, ok}, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, {28'd0, req_ready}, 0);
    chk({tag, "_rsp_valid"}, {28'd0, rsp_valid}, 0);
    chk({tag, "_rsp_d"}, {16'd0, rsp_d}, 0);
    chk({tag, "_rsp_id"}, {30'd0, rsp_id}, 0);
    chk({tag, "_adder_ab"}, {adder_a, adder_b}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  task automatic d2_txn(input int id, input logic [W-1:0] ea, input logic [W-1:0] eb,
                        input logic [W-1:0] ed);
    bit ok = 1'b0;
    int acc = 0;
    r2_valid[id] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (r2_ready[id]) begin ok = 1'b1; acc = cyc; break; end
    end
    chk("lat2_accept_timeout", {31'd0, ok}, 1);
    @(posedge clk); #1;
    r2_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        chk("lat2_adder_a", {16'd0, a2}, {16'd0, ea});
        chk("lat2_adder_b", {16'd0, b2}, {16'd0, eb});
        chk("lat2_no_rsp_yet", {28'd0, rsp2_valid}, 0);
      end else begin
        chk("lat2_rsp_latency", cyc - acc, 4);
        chk("lat2_rsp_valid", {28'd0, rsp2_valid}, 32'(1) << id);
        chk("lat2_rsp_d", {16'd0, rsp2_d}, {16'd0, ed});
        chk("lat2_rsp_id", {30'd0, rsp2_id}, id);
      end
    end
    @(negedge clk);
  endtask

  initial begin : stim
    int n, last;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset");

    // Round robin: all four valid, order 0,1,2,3,0, one accept every 3 cycles.
    @(posedge clk); #1;
    gq = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111;
    n = 0; last = 0;
    for (int k = 0; k < 40 && n < 5; k++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) begin
        if (n > 0) chk("rr_spacing", cyc - last, 3);
        last = cyc;
        n++;
      end
    end
    chk("rr_accepts", n, 5);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Single request from requester 2: 0x1234 + 0x0101.
    @(posedge clk); #1;
    gq.push_back(2);
    req_valid = 4'b0100;
    wait_ready(2);
    chk("single_req_ready", {28'd0, req_ready}, 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Backpressure on requester 1 while requester 2 waits.
    @(posedge clk); #1;
    gq.push_back(1); gq.push_back(2);
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    wait_ready(1);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_rsp_valid", {28'd0, rsp_valid}, 32'b0010);
      chk("bp_rsp_d", {16'd0, rsp_d}, 32'h0100);
      chk("bp_rsp_id", {30'd0, rsp_id}, 1);
      chk("bp_req_ready", {28'd0, req_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 4'b1111;
    @(negedge clk);
    chk("bp_req_ready_handshake_cycle", {28'd0, req_ready}, 0);
    @(negedge clk);
    chk("bp_req_ready_after", {28'd0, req_ready}, 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Reset during ISSUE, then during RESP; pointer restarts at 0 each time.
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      gq.push_back(2);
      if (t == 1) rsp_ready = 4'b1011;
      req_valid = 4'b0100;
      wait_ready(2);
      @(posedge clk); #1;
      req_valid = '0;
      if (t == 1) begin
        wait_rsp();
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 4'b1111;
      @(negedge clk);
      chk_reset_outs(t == 0 ? "rst_issue" : "rst_resp");
      repeat (2) @(negedge clk);
      chk("rst_no_rsp", {28'd0, rsp_valid}, 0);
      @(posedge clk); #1;
      gq.push_back(1); gq.push_back(3);
      req_valid = 4'b1010;
      wait_ready(1);
      @(posedge clk); #1;
      req_valid = 4'b1000;
      wait_ready(3);
      @(posedge clk); #1;
      req_valid = '0;
      drain();
    end

    // Withdrawn request: requester 3 pulses valid during RESP for requester 0.
    @(posedge clk); #1;
    gq.push_back(0); gq.push_back(1);
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp();
    @(posedge clk); #1;
    req_valid = 4'b1000;
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk); #1;
    rsp_ready = 4'b1111;
    @(posedge clk); #1;
    req_valid = 4'b0010;
    wait_ready(1);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Registered adder, latency 2: wrap-around sum then a distinct sum.
    @(posedge clk); #1;
    d2_txn(0, 16'hFFFF, 16'h0001, 16'h0000);
    @(posedge clk); #1;
    d2_txn(1, 16'h0100, 16'h0023, 16'h0123);

    repeat (3) @(negedge clk);
    chk("grant_queue_empty", gq.size(), 0);
    chk("rsp_queue_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/conf_int_add__rr_sched.md
# conf_int_add__rr_sched

Round-robin scheduler that shares one configurable integer adder instance (any exact or approximate, noFF or registered variant) among NUM_REQ requesters. Each requester submits an operand pair over a valid/ready handshake. The scheduler grants one request at a time, drives the shared adder's operand ports, and waits the adder's fixed latency. It then registers the sum and returns it to the granted requester over a valid/ready response handshake.

## Interface
- DATA_PATH_BITWIDTH, 16, operand/result width; equals the adder's DATA_PATH_BITWIDTH
- NUM_REQ, 4, number of requesters (2..8)
- REQ_IDX_W, 2, width of requester index; equals ceil(log2(NUM_REQ))
- ADDER_LAT, 0, cycles from adder_a/adder_b stable to adder_d valid (0 = combinational noFF adder; max 7)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- req_a  in  NUM_REQ*DATA_PATH_BITWIDTH  operand a, requester i at bits [i*W +: W]
- req_b  in  NUM_REQ*DATA_PATH_BITWIDTH  operand b, same packing
- adder_a  out  DATA_PATH_BITWIDTH  to shared adder input a
- adder_b  out  DATA_PATH_BITWIDTH  to shared adder input b
- adder_d  in  DATA_PATH_BITWIDTH  from shared adder output d
- rsp_valid  out  NUM_REQ  one-hot result valid to the granted requester
- rsp_ready  in  NUM_REQ  per-requester result accept
- rsp_d  out  DATA_PATH_BITWIDTH  registered sum
- rsp_id  out  REQ_IDX_W  index of the requester owning rsp_d
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Arbiter scans req_valid starting at rr_ptr, ascending, wrapping at NUM_REQ. The first set bit is the grant g.
  - req_ready[g] = 1 combinationally in IDLE only. All other bits are 0. With no valid request, req_ready = 0.
  - On req_valid[g] & req_ready[g]: latch req_a[g] and req_b[g] into op_a/op_b, latch g into gnt_id, set rr_ptr = (g+1) mod NUM_REQ, clear lat_cnt, go to ISSUE.
- ISSUE:
  - adder_a = op_a and adder_b = op_b, held stable for the whole state.
  - lat_cnt increments each cycle.
  - When lat_cnt == ADDER_LAT: capture adder_d into rsp_d, set rsp_id = gnt_id, go to RESP.
- RESP:
  - rsp_valid[gnt_id] = 1. rsp_d and rsp_id are held stable.
  - On rsp_ready[gnt_id]: clear rsp_valid and go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Outside ISSUE, adder_a/adder_b keep their last driven values; they return to 0 only on reset. This limits switching on the shared adder.
- Arithmetic:
  - The scheduler performs no arithmetic. rsp_d is exactly the adder's W-bit output.
  - Carry-out is not available; wrap-around is the adder's behaviour (exact adder: 0xFFFF+0x0001 -> 0x0000).
  - An approximate adder's error passes through unmodified.
- Fairness: a requester holding req_valid is granted within NUM_REQ-1 intervening transactions.
- Requesters must hold req_valid, req_a and req_b stable until accepted. Dropping req_valid before acceptance withdraws the request; no state is kept for it.
- Illegal parameters (NUM_REQ > 2^REQ_IDX_W, ADDER_LAT > 7) are unsupported and need not be detected.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, req_ready = 0, rsp_valid = 0, rsp_d = 0, rsp_id = 0, adder_a = 0, adder_b = 0, busy = 0, lat_cnt = 0.
- Reset mid-operation (ISSUE or RESP): the transaction is dropped without a response, and all registers take their reset values on that edge.
- Accept edge = cycle 0. ISSUE occupies cycles 1..1+ADDER_LAT. rsp_valid is high from cycle 2+ADDER_LAT.
- Minimum occupancy is 3+ADDER_LAT cycles per transaction when rsp_ready is held high. The next accept can occur on the edge after the RESP handshake.
- Simultaneous request and response: a new request is never accepted in RESP. req_ready stays 0 until the cycle after RESP exits.
- rsp_ready asserted before rsp_valid has no effect.
- busy = (state != IDLE), registered with the state.

## Test plan
- Single request, ADDER_LAT=0, exact adder: requester 2 sends a=0x1234, b=0x0101 with rsp_ready high -> req_ready[2] in the request cycle; rsp_valid=4'b0100, rsp_d=0x1335, rsp_id=2 exactly 2 cycles after accept.
- Round-robin, all four requesters valid continuously, rsp_ready high -> grant order 0,1,2,3,0 with rr_ptr wrapping 3->0; one accept every 3 cycles.
- Backpressure: requester 1's rsp_ready held low 5 cycles -> rsp_valid[1], rsp_d and rsp_id stable throughout; req_ready stays 0 to every requester until 1 cycle after rsp_ready rises.
- ADDER_LAT=2 with a registered adder model, a=0xFFFF, b=0x0001 -> adder_a/adder_b stable for 3 ISSUE cycles; rsp_d=0x0000; rsp_valid asserted 4 cycles after accept.
- Reset during ISSUE and again during RESP -> on the following cycle all outputs are at reset values, no rsp_valid appears for the dropped request, and the next grant starts from requester 0.
- Withdrawn request: requester 3 raises then drops req_valid while the scheduler is in RESP for requester 0 -> requester 3 is never granted and requester 1's later request is granted next.
